// File: rtl/clksel_sched.sv
`default_nettype none
// ============================================================================
//  Module   : clksel_sched
//  Purpose  : Sequences the glitch-free CPU clock switch between the local
//             high-speed clock and the slow host clock. It requests the fast
//             clock after a run of idle cycles and waits for the switch's
//             synchronised feedback before releasing the CPU. It stalls the
//             CPU through every transition and on host accesses made while
//             running fast.
//  Ports    : hsclk_in        high-speed clock, the only clock domain here
//             rst_b           asynchronous active-low reset
//             fast_en         software permission to run fast
//             host_req        current CPU cycle targets host memory/IO
//             hsclk_selected  switch feedback (foreign domain), fast active
//             lsclk_selected  switch feedback (foreign domain), slow active
//             hsclk_sel       registered request to the switch, 1 = fast
//             cpu_rdy         0 stalls the CPU
//             state_o         current state encoding (debug)
//             sw_err          sticky: a transition exceeded TIMEOUT cycles
//  Revision : 1.0  initial release
// ============================================================================
module clksel_sched #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int HOLD_W      = 5,
   parameter int TIMEOUT     = 255,
   parameter int TO_W        = 8
) (
   input  logic       hsclk_in,
   input  logic       rst_b,
   input  logic       fast_en,
   input  logic       host_req,
   input  logic       hsclk_selected,
   input  logic       lsclk_selected,
   output logic       hsclk_sel,
   output logic       cpu_rdy,
   output logic [2:0] state_o,
   output logic       sw_err
);

   typedef enum logic [2:0] {
      ST_LS_RUN = 3'd0,
      ST_TO_HS  = 3'd1,
      ST_HS_RUN = 3'd2,
      ST_TO_LS  = 3'd3
   } state_t;

   localparam logic [HOLD_W-1:0] C_HOLD_INIT = HOLD_W'(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] C_HOLD_ONE  = HOLD_W'(1);
   localparam logic [TO_W-1:0]   C_TO_MAX    = TO_W'(TIMEOUT);

   // ------------------------------------------------------------------------
   // Feedback synchronisers. The ls chain resets to 1 because the switch
   // itself comes out of reset driving the slow clock.
   // ------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] hs_sync_q;
   logic [SYNC_STAGES-1:0] ls_sync_q;
   logic                   hs_ack;
   logic                   ls_ack;

   always_ff @(posedge hsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         hs_sync_q <= '0;
         ls_sync_q <= '1;
      end else begin
         hs_sync_q <= {hs_sync_q[SYNC_STAGES-2:0], hsclk_selected};
         ls_sync_q <= {ls_sync_q[SYNC_STAGES-2:0], lsclk_selected};
      end
   end

   assign hs_ack = hs_sync_q[SYNC_STAGES-1];
   assign ls_ack = ls_sync_q[SYNC_STAGES-1];

   // A transition completes only on an unambiguous one-hot ack pair; both
   // high or both low (make/break windows of the switch) keep us waiting.
   logic w_hs_done;
   logic w_ls_done;
   logic w_go_slow;

   assign w_hs_done = hs_ack & ~ls_ack;
   assign w_ls_done = ls_ack & ~hs_ack;
   assign w_go_slow = host_req | ~fast_en;

   // ------------------------------------------------------------------------
   // State machine
   // ------------------------------------------------------------------------
   state_t              state_q,     state_d;
   logic                hsclk_sel_q, hsclk_sel_d;
   logic                rdy_q,       rdy_d;
   logic                sw_err_q,    sw_err_d;
   logic [HOLD_W-1:0]   hold_q,      hold_d;
   logic [TO_W-1:0]     to_q,        to_d;
   logic [TO_W-1:0]     w_to_inc;

   // Saturating at TIMEOUT keeps the counter meaningful however long the
   // switch stalls.
   assign w_to_inc = (to_q >= C_TO_MAX) ? C_TO_MAX : (to_q + TO_W'(1));

   always_comb begin
      state_d  = state_q;
      hold_d   = C_HOLD_INIT;   // outside LS_RUN the counter sits preloaded
      to_d     = '0;            // outside transitions the counter sits clear
      sw_err_d = sw_err_q;

      case (state_q)
         ST_LS_RUN: begin
            if (w_go_slow) begin
               hold_d = C_HOLD_INIT;
            end else if (hold_q <= C_HOLD_ONE) begin
               state_d = ST_TO_HS;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         ST_TO_HS: begin
            // No reversal here even if host_req/!fast_en appear: the switch
            // must finish its handshake before being asked to go back.
            if (w_hs_done) begin
               state_d = ST_HS_RUN;
            end else begin
               to_d = w_to_inc;
               if (w_to_inc == C_TO_MAX) begin
                  sw_err_d = 1'b1;
               end
            end
         end
         ST_HS_RUN: begin
            if (w_go_slow) begin
               state_d = ST_TO_LS;
            end
         end
         ST_TO_LS: begin
            if (w_ls_done) begin
               state_d = ST_LS_RUN;
            end else begin
               to_d = w_to_inc;
               if (w_to_inc == C_TO_MAX) begin
                  sw_err_d = 1'b1;
               end
            end
         end
         default: begin
            // Corrupted encoding: heading to slow is always safe.
            state_d = ST_TO_LS;
         end
      endcase

      hsclk_sel_d = (state_d == ST_TO_HS) || (state_d == ST_HS_RUN);
      rdy_d       = (state_d == ST_LS_RUN) || (state_d == ST_HS_RUN);
   end

   always_ff @(posedge hsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= ST_LS_RUN;
         hsclk_sel_q <= 1'b0;
         rdy_q       <= 1'b1;
         sw_err_q    <= 1'b0;
         hold_q      <= C_HOLD_INIT;
         to_q        <= '0;
      end else begin
         state_q     <= state_d;
         hsclk_sel_q <= hsclk_sel_d;
         rdy_q       <= rdy_d;
         sw_err_q    <= sw_err_d;
         hold_q      <= hold_d;
         to_q        <= to_d;
      end
   end

   // In HS_RUN a host access must stall in the very cycle it is decoded,
   // so that gating is combinational on top of the registered ready.
   assign cpu_rdy   = rdy_q & ~((state_q == ST_HS_RUN) & host_req);
   assign hsclk_sel = hsclk_sel_q;
   assign state_o   = state_q;
   assign sw_err    = sw_err_q;

endmodule
`default_nettype wire

// File: tb/tb_clksel_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clksel_sched
//  Purpose  : Self-checking bench for clksel_sched. A behavioural model
//             predicts the outputs after every clock edge and queues them;
//             a monitor compares the DUT on the falling edge. A small clock
//             switch emulator answers hsclk_sel with delayed feedback.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clksel_sched;

   localparam int SYNC = 2;
   localparam int HOLD = 16;
   localparam int TMO  = 255;

   logic       hsclk_in       = 1'b0;
   logic       rst_b          = 1'b0;
   logic       fast_en        = 1'b0;
   logic       host_req       = 1'b0;
   logic       hsclk_selected = 1'b0;
   logic       lsclk_selected = 1'b1;
   logic       hsclk_sel;
   logic       cpu_rdy;
   logic [2:0] state_o;
   logic       sw_err;

   clksel_sched #(
      .SYNC_STAGES (SYNC),
      .HOLD_CYCLES (HOLD),
      .HOLD_W      (5),
      .TIMEOUT     (TMO),
      .TO_W        (8)
   ) u_dut (
      .hsclk_in       (hsclk_in),
      .rst_b          (rst_b),
      .fast_en        (fast_en),
      .host_req       (host_req),
      .hsclk_selected (hsclk_selected),
      .lsclk_selected (lsclk_selected),
      .hsclk_sel      (hsclk_sel),
      .cpu_rdy        (cpu_rdy),
      .state_o        (state_o),
      .sw_err         (sw_err)
   );

   always #5 hsclk_in = ~hsclk_in;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: mode 0 slow run, 1 going fast, 2 fast run, 3 going
   // slow. idle counts consecutive idle slow cycles, wait counts cycles
   // spent waiting on the switch.
   // ------------------------------------------------------------------------
   typedef struct {
      int st;
      bit sel;
      int rdy_mode;   // 0 / 1 fixed, 2 = follows !host_req
      bit err;
   } exp_t;

   exp_t sb[$];
   bit   started = 1'b0;
   int   m_mode, m_idle, m_wait;
   bit   m_err;
   bit   hs_hist[$];
   bit   ls_hist[$];
   bit   m_hs, m_ls;

   task automatic m_reset();
      m_mode = 0; m_idle = 0; m_wait = 0; m_err = 1'b0;
      hs_hist.delete(); ls_hist.delete();
      for (int i = 0; i < SYNC; i++) begin
         hs_hist.push_back(1'b0);
         ls_hist.push_back(1'b1);
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.st       = m_mode;
      e.sel      = (m_mode == 1) || (m_mode == 2);
      e.rdy_mode = (m_mode == 0) ? 1 : ((m_mode == 2) ? 2 : 0);
      e.err      = m_err;
      sb.push_back(e);
   endtask

   task automatic m_wait_step();
      m_wait = (m_wait + 1 > TMO) ? TMO : m_wait + 1;
      if (m_wait == TMO) m_err = 1'b1;
   endtask

   always @(posedge hsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         m_reset();
         sb.delete();
         push_exp();
      end else begin
         // Acks seen now are the feedback sampled SYNC edges ago.
         m_hs = hs_hist.pop_front();
         m_ls = ls_hist.pop_front();
         hs_hist.push_back(hsclk_selected);
         ls_hist.push_back(lsclk_selected);
         case (m_mode)
            0: begin
               if (host_req || !fast_en) m_idle = 0;
               else m_idle++;
               if (m_idle == HOLD) begin m_mode = 1; m_wait = 0; m_idle = 0; end
            end
            1: begin
               if (m_hs && !m_ls) m_mode = 2;
               else m_wait_step();
            end
            2: begin
               if (host_req || !fast_en) begin m_mode = 3; m_wait = 0; end
            end
            default: begin
               if (m_ls && !m_hs) begin m_mode = 0; m_idle = 0; end
               else m_wait_step();
            end
         endcase
         push_exp();
      end
      started = 1'b1;
   end

   // ------------------------------------------------------------------------
   // Monitor: compare the newest prediction on every falling edge.
   // ------------------------------------------------------------------------
   exp_t mon_e;
   always @(negedge hsclk_in) begin
      if (sb.size() == 0) begin
         if (started) chk("scoreboard_empty", 0, 1);
      end else begin
         while (sb.size() > 1) void'(sb.pop_front());
         mon_e = sb.pop_front();
         chk("state_o",   int'(state_o),   mon_e.st);
         chk("hsclk_sel", int'(hsclk_sel), int'(mon_e.sel));
         chk("cpu_rdy",   int'(cpu_rdy),
             (mon_e.rdy_mode == 2) ? int'(!host_req) : mon_e.rdy_mode);
         chk("sw_err",    int'(sw_err),    int'(mon_e.err));
      end
   end

   // ------------------------------------------------------------------------
   // Clock switch emulator: after sw_delay cycles of request/feedback
   // disagreement it drops both feedbacks for one cycle, then settles.
   // ------------------------------------------------------------------------
   int sw_delay = 5;
   bit withhold = 1'b0;
   int sw_cnt   = 0;
   bit sw_done;

   always @(posedge hsclk_in) begin
      #1;
      if (!rst_b) begin
         hsclk_selected = 1'b0;
         lsclk_selected = 1'b1;
         sw_cnt = 0;
      end else begin
         sw_done = hsclk_sel ? (hsclk_selected && !lsclk_selected)
                             : (lsclk_selected && !hsclk_selected);
         if (sw_done) begin
            sw_cnt = 0;
         end else if (!withhold) begin
            sw_cnt++;
            if (sw_cnt == sw_delay) begin
               hsclk_selected = 1'b0;
               lsclk_selected = 1'b0;
            end else if (sw_cnt > sw_delay) begin
               hsclk_selected = hsclk_sel;
               lsclk_selected = !hsclk_sel;
               sw_cnt = 0;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge hsclk_in);
         #1;
      end
   endtask

   task automatic wait_state(input int s, input int budget, input string name);
      int k = 0;
      while (int'(state_o) != s && k < budget) begin
         cyc(1);
         k++;
      end
      chk(name, int'(state_o), s);
   endtask

   initial begin
      rst_b = 1'b0; fast_en = 1'b0; host_req = 1'b0;
      cyc(3);
      rst_b = 1'b1;
      cyc(100);

      // Upswitch after the idle hold, switch acks after 5 cycles.
      fast_en  = 1'b1;
      sw_delay = 5;
      wait_state(2, 60, "reach_hs_run");
      cyc(5);

      // Host access while fast: stall, go slow, access completes slow.
      host_req = 1'b1;
      sw_delay = 7;
      wait_state(0, 40, "reach_ls_run");
      cyc(1);
      host_req = 1'b0;

      // Periodic host accesses keep the hold counter from expiring.
      for (int i = 0; i < 20; i++) begin
         host_req = 1'b1;
         cyc(1);
         host_req = 1'b0;
         cyc(9);
      end
      chk("periodic_stays_slow", int'(state_o), 0);

      // Host access arriving mid upswitch: finish, then come straight back.
      wait_state(1, 30, "reach_to_hs");
      host_req = 1'b1;
      wait_state(0, 60, "back_to_ls");
      cyc(1);
      host_req = 1'b0;

      // Withheld acks: sticky error, FSM keeps waiting, late ack completes.
      withhold = 1'b1;
      wait_state(1, 40, "reach_to_hs_wh");
      cyc(300);
      chk("to_stuck_state", int'(state_o), 1);
      withhold = 1'b0;
      wait_state(2, 40, "late_ack_hs_run");
      chk("err_sticky", int'(sw_err), 1);
      cyc(3);
      #2;
      rst_b = 1'b0;
      #1;
      chk("rst_state", int'(state_o), 0);
      chk("rst_sel",   int'(hsclk_sel), 0);
      chk("rst_rdy",   int'(cpu_rdy), 1);
      chk("rst_err",   int'(sw_err), 0);
      cyc(2);
      rst_b = 1'b1;

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         fast_en  = ($urandom_range(0, 19) != 0);
         host_req = ($urandom_range(0, 29) == 0);
         sw_delay = $urandom_range(1, 9);
         if ($urandom_range(0, 999) == 0) begin
            rst_b = 1'b0;
            cyc(2);
            rst_b = 1'b1;
         end
         cyc(1);
      end
      host_req = 1'b0;
      cyc(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/clksel_sched.md
Name: clksel_sched

Overview:
- Sequences the glitch-free CPU clock switch between the high-speed (local) and low-speed (host motherboard) clocks.
- Decides when to request the fast clock via hsclk_sel and waits for the switch's selected-clock feedback before releasing the CPU.
- Holds the CPU through every transition and on host-bus accesses made while running fast.
- Applies hysteresis so back-to-back host accesses do not thrash the switch.

Parameters:
- SYNC_STAGES, 2, flop stages on each feedback synchroniser (min 2).
- HOLD_CYCLES, 16, consecutive idle hsclk_in cycles in LS_RUN before an upswitch (1..2^HOLD_W-1).
- HOLD_W, 5, hold counter width.
- TIMEOUT, 255, hsclk_in cycles in a transition state before sw_err sets (1..2^TO_W-1).
- TO_W, 8, timeout counter width.

Ports:
- hsclk_in  input  1  high-speed clock; all state is in this domain.
- rst_b  input  1  reset, asynchronous, active-low.
- fast_en  input  1  level; software permission to run on the fast clock.
- host_req  input  1  level, hsclk_in-synchronous; the current CPU cycle decodes to host memory/IO.
- hsclk_selected  input  1  switch feedback, foreign domain; the fast clock is driving the CPU.
- lsclk_selected  input  1  switch feedback, foreign domain; the slow clock is driving the CPU.
- hsclk_sel  output  1  registered request to the clock switch; 1 selects the fast clock.
- cpu_rdy  output  1  CPU ready; 0 stalls the CPU.
- state_o  output  3  current state encoding, for debug.
- sw_err  output  1  sticky flag: a switch transition exceeded TIMEOUT.

Behaviour:
- Feedback synchronisation:
  - hsclk_selected and lsclk_selected each pass through SYNC_STAGES flops; the results are hs_ack and ls_ack.
  - Async reset values: hs chain all 0, ls chain all 1.
- States and encodings: LS_RUN=0, TO_HS=1, HS_RUN=2, TO_LS=3. Encodings 4..7 are illegal and recover to TO_LS.
- Reset values:
  - state=LS_RUN, hsclk_sel=0, cpu_rdy=1, sw_err=0.
  - hold counter=HOLD_CYCLES, timeout counter=0.
- LS_RUN:
  - hsclk_sel=0, cpu_rdy=1.
  - Hold counter reloads to HOLD_CYCLES on state entry and on any cycle with host_req=1 or fast_en=0; otherwise it decrements.
  - On the edge where the counter is 1 and decrements, move to TO_HS. This gives exactly HOLD_CYCLES idle cycles, then TO_HS on the next edge.
- TO_HS:
  - hsclk_sel=1 from the entry edge; cpu_rdy=0.
  - Exit to HS_RUN when hs_ack=1 and ls_ack=0.
  - If host_req or !fast_en appears here, the transition still completes first; no mid-transition reversal.
- HS_RUN:
  - hsclk_sel=1.
  - cpu_rdy = !host_req, combinational, so a host access stalls in the same cycle.
  - If host_req=1 or fast_en=0, go to TO_LS on the next edge.
- TO_LS:
  - hsclk_sel=0 from the entry edge; cpu_rdy=0.
  - Exit to LS_RUN when ls_ack=1 and hs_ack=0.
  - The stalled host access then proceeds, with cpu_rdy=1 in LS_RUN.
- Ack decode: hs_ack=ls_ack=1 or hs_ack=ls_ack=0 never completes a transition; keep waiting.
- Timeout:
  - The counter clears on entry to TO_HS/TO_LS and increments in those states, saturating.
  - Reaching TIMEOUT sets sw_err; it clears only on reset.
  - The FSM keeps waiting; it does not force a state.
- Async reset mid-transition returns to the reset values immediately. The switch also resets to slow, so no handshake is replayed.

Test Plan:
- Reset, fast_en=0 for 100 cycles -> state_o=0, hsclk_sel=0, cpu_rdy=1, sw_err=0 throughout.
- fast_en=1, host_req=0 -> TO_HS after exactly 16 idle cycles. Model drives hsclk_selected=1, lsclk_selected=0 after 5 cycles -> HS_RUN 2 cycles later (sync), then cpu_rdy=1.
- In HS_RUN pulse host_req=1 -> cpu_rdy=0 the same cycle, TO_LS next edge. Model acks slow after 7 cycles -> LS_RUN, cpu_rdy=1. Re-upswitch only after 16 further idle cycles.
- host_req every 10 cycles in LS_RUN -> hold counter never expires, hsclk_sel stays 0.
- host_req asserted during TO_HS -> HS_RUN reached after ack, then TO_LS on the next edge; cpu_rdy=0 continuously.
- Model withholds acks in TO_HS -> sw_err=1 at cycle 255 of TO_HS, state stays 1. Late ack -> HS_RUN with sw_err still 1. Assert rst_b=0 -> all reset values.
